// File: rtl/piso_pkg.sv
// piso_pkg: shared types and constants for the PISO serializer
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam bit LSB_FIRST_ORDER = 1'b0;
  localparam bit MSB_FIRST_ORDER = 1'b1;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/piso_hold_reg.sv
// piso_hold_reg: one-entry holding buffer with load, drain and full flag
module piso_hold_reg #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         drain,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         full
);
  // capture a word on load, release the slot on drain
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
endmodule

// File: rtl/piso_serializer_tx.sv
// piso_serializer_tx: parallel-in serial-out transmitter with one-word holding buffer
module piso_serializer_tx
  import piso_pkg::*;
#(
  parameter int N         = 6,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pi_data,
  input  logic         pi_valid,
  output logic         pi_ready,
  output logic         so,
  output logic         so_valid,
  output logic         so_last,
  output logic         busy
);
  localparam int CNT_W = cnt_w(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  state_t           state, state_n;
  logic [N-1:0]     shreg, shreg_n, shifted, hold_q;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             hold_full, hold_load, hold_drain, accept, at_last;
  piso_hold_reg #(.N(N)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .drain (hold_drain),
    .d     (pi_data),
    .q     (hold_q),
    .full  (hold_full)
  );
  assign pi_ready = !hold_full;
  assign accept   = pi_valid && pi_ready;
  assign at_last  = (state == SHIFT) && (cnt == LAST);
  assign shifted  = MSB_FIRST ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};
  assign so_valid = (state == SHIFT);
  assign so_last  = at_last;
  assign so       = so_valid && (MSB_FIRST ? shreg[N-1] : shreg[0]);
  assign busy     = (state == SHIFT) || hold_full;
  // state, shift register and bit counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
    end
  // next state: load, shift, or at the last bit chain into held/bypassed word
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    if (state == IDLE) begin
      if (accept) begin
        shreg_n = pi_data;
        cnt_n   = '0;
        state_n = SHIFT;
      end
    end else if (at_last) begin
      cnt_n = '0;
      if (hold_full) begin
        shreg_n    = hold_q;
        hold_drain = 1'b1;
      end else if (accept) begin
        shreg_n = pi_data;
      end else begin
        shreg_n = shifted;
        state_n = IDLE;
      end
    end else begin
      shreg_n   = shifted;
      cnt_n     = cnt + 1'b1;
      hold_load = accept;
    end
  end
endmodule
